data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-port responder for the single-cycle RISC-V core. Serves loads
//   combinationally and commits stores on the rising clock edge. It backs a
//   word-organised RAM and a 16-byte MMIO window holding a console TX FIFO,
//   a status register and a 64-bit free-running cycle counter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   memwrite   store request this cycle
//   memsize    access size/sign (RISC-V funct3: LB/LH/LW/LBU/LHU)
//   addr       byte address
//   writedata  store data, low-aligned
//   readdata   combinational load data
//   tx_data    TX FIFO head byte
//   tx_valid   TX FIFO non-empty
//   tx_ready   consumer accepts the head this cycle
//   err        sticky access-error flag
//
// MMIO map (word access only)
//   +0 TXDATA   write pushes writedata[7:0]; reads 0
//   +4 STATUS   {28'b0, err, ovf, full, empty}; write-1-to-clear bits 3/2
//   +8 CYCLE_LO counter[31:0]; a read also snapshots counter[63:32]
//   +C CYCLE_HI snapshot of counter[63:32]
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [31:0] CYCLE_LO_ADDR = MMIO_BASE + 32'd8;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic       is_byte, is_half, is_word, size_ok, misalign;
  logic       ram_hit, mmio_hit, acc_err, ram_ok, mmio_ok;
  logic [1:0] mmio_off;

  always_comb begin
    is_byte  = (memsize == SZ_B) || (memsize == SZ_BU);
    is_half  = (memsize == SZ_H) || (memsize == SZ_HU);
    is_word  = (memsize == SZ_W);
    size_ok  = is_byte || is_half || is_word;
    misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    ram_hit  = (addr[31:AW+2] == '0);
    mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    mmio_off = addr[3:2];
    // Every presented address is an access; MMIO only accepts aligned words.
    acc_err  = !size_ok || misalign || !(ram_hit || mmio_hit) ||
               (mmio_hit && !is_word);
    ram_ok   = ram_hit && !acc_err;
    mmio_ok  = mmio_hit && !ram_hit && !acc_err;
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   shadow_q, shadow_d;

  logic          empty, full, pop, push_req, push, ovf_set, clr_err, clr_ovf;
  logic [31:0]   status;

  // ---------------------------------------------------------------------
  // RAM load path and store lane merge
  // ---------------------------------------------------------------------
  logic [AW-1:0] widx;
  logic [31:0]   ram_word, ram_rdata, mmio_rdata, wmask, wlane;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          ram_we;

  always_comb begin
    widx     = addr[AW+1:2];
    ram_word = mem_q[widx];
    case (addr[1:0])
      2'd0:    ld_byte = ram_word[7:0];
      2'd1:    ld_byte = ram_word[15:8];
      2'd2:    ld_byte = ram_word[23:16];
      default: ld_byte = ram_word[31:24];
    endcase
    ld_half = addr[1] ? ram_word[31:16] : ram_word[15:0];
    case (memsize)
      SZ_B:    ram_rdata = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ram_rdata = {24'b0, ld_byte};
      SZ_H:    ram_rdata = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ram_rdata = {16'b0, ld_half};
      SZ_W:    ram_rdata = ram_word;
      default: ram_rdata = '0;
    endcase

    wmask = '0;
    wlane = writedata;
    if (is_byte) begin
      wlane = {4{writedata[7:0]}};
      case (addr[1:0])
        2'd0:    wmask = 32'h0000_00FF;
        2'd1:    wmask = 32'h0000_FF00;
        2'd2:    wmask = 32'h00FF_0000;
        default: wmask = 32'hFF00_0000;
      endcase
    end else if (is_half) begin
      wlane = {2{writedata[15:0]}};
      wmask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    end else if (is_word) begin
      wmask = '1;
    end
    ram_we = memwrite && ram_ok;
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[widx] <= (ram_word & ~wmask) | (wlane & wmask);
  end

  // ---------------------------------------------------------------------
  // MMIO read mux and final readdata
  // ---------------------------------------------------------------------
  always_comb begin
    status = {28'b0, err_q, ovf_q, full, empty};
    case (mmio_off)
      2'd0:    mmio_rdata = '0;
      2'd1:    mmio_rdata = status;
      2'd2:    mmio_rdata = cycle_q[31:0];
      default: mmio_rdata = shadow_q;
    endcase
    if (ram_ok)       readdata = ram_rdata;
    else if (mmio_ok) readdata = mmio_rdata;
    else              readdata = '0;
  end

  // ---------------------------------------------------------------------
  // TX FIFO, flags, counter next-state
  // ---------------------------------------------------------------------
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FIFO_FULL_CNT);
    pop      = !empty && tx_ready;
    push_req = memwrite && mmio_ok && (mmio_off == 2'd0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    clr_err  = memwrite && mmio_ok && (mmio_off == 2'd1) && writedata[3];
    clr_ovf  = memwrite && mmio_ok && (mmio_off == 2'd1) && writedata[2];

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over a same-cycle write-1-to-clear.
    err_d    = acc_err || (err_q && !clr_err);
    ovf_d    = ovf_set || (ovf_q && !clr_ovf);

    cycle_d  = cycle_q + 64'd1;
    shadow_d = (addr == CYCLE_LO_ADDR && !memwrite) ? cycle_q[63:32] : shadow_q;

    tx_valid = !empty;
    tx_data  = fifo_q[rd_ptr_q];
    err      = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      cycle_q  <= '0;
      shadow_q <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= writedata[7:0];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      cycle_q  <= cycle_d;
      shadow_q <= shadow_d;
    end
  end

endmodule
